// File: rtl/cg_pkg.sv
// ---------------------------------------------------------------------------
// cg_pkg
// Shared definitions for the vector bank slice: default geometry of a bank
// (element width, elements per row, rows per bank), the row type that goes
// with that default geometry, and a helper that sizes row address buses.
// ---------------------------------------------------------------------------
package cg_pkg;

   localparam int cg_element_width = 32;
   localparam int cg_no_of_units   = 8;
   localparam int cg_depth         = 64;

   localparam int cg_row_width = cg_element_width * cg_no_of_units;

   typedef logic [cg_row_width-1:0] cg_row_t;

   // A one-row bank still needs a one-bit address bus.
   function automatic int cg_addr_width(input int rows_in_bank);
      return (rows_in_bank > 1) ? $clog2(rows_in_bank) : 1;
   endfunction

endpackage

// File: rtl/cg_row_ram.sv
// ---------------------------------------------------------------------------
// cg_row_ram
// One bank of row storage: a single write port and two independent read
// ports, both registered. Contents are never cleared; reset only clears the
// read-port output registers so the bank's outputs start at zero.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low; clears rd0_data / rd1_data only
//   we        write strobe
//   wr_addr   write row address
//   wr_data   row to store
//   rd0_en    load enable for read port 0 (holds its value when low)
//   rd0_addr  read port 0 row address
//   rd0_data  read port 0 registered row
//   rd1_addr  read port 1 row address (loaded every cycle)
//   rd1_data  read port 1 registered row
// ---------------------------------------------------------------------------
module cg_row_ram
   import cg_pkg::*;
#(
   parameter int width      = cg_row_width,
   parameter int depth      = cg_depth,
   parameter int addr_width = cg_addr_width(depth)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [addr_width-1:0] wr_addr,
   input  logic [width-1:0]      wr_data,
   input  logic                  rd0_en,
   input  logic [addr_width-1:0] rd0_addr,
   output logic [width-1:0]      rd0_data,
   input  logic [addr_width-1:0] rd1_addr,
   output logic [width-1:0]      rd1_data
);

   logic [width-1:0] mem [depth];

   // Storage array kept free of reset so it maps onto RAM macros.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Port 0 only advances when asked, which lets the owner hold a row.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd0_data <= '0;
      end else if (rd0_en) begin
         rd0_data <= mem[rd0_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd1_data <= '0;
      end else begin
         rd1_data <= mem[rd1_addr];
      end
   end

endmodule

// File: rtl/cg_vector_bank.sv
// ---------------------------------------------------------------------------
// cg_vector_bank
// Double-buffered row store. Bank A and bank B swap roles on each swap
// pulse: bank_sel picks the read bank, the other bank takes writes. The read
// bank is offered through a sequential streaming port (read_req / read_data)
// and a registered random-access port (rand_addr / rand_data).
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   total       element count; rows = total / no_of_units, latched at reset
//               release and at every swap
//   read_req    request the next sequential row of the read bank
//   read_data   row returned for read_req, held between reads
//   read_valid  one-cycle qualifier for read_data
//   read_done   pulses with read_valid of the last row
//   rand_addr   random row address into the read bank
//   rand_data   read-bank row at rand_addr, one cycle later
//   wr_en       write strobe into the write bank
//   wr_addr     row address for the write
//   wr_data     row to write
//   swap        exchange banks, restart the stream, re-latch rows
//   err         sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module cg_vector_bank
   import cg_pkg::*;
#(
   parameter int element_width = cg_element_width,
   parameter int no_of_units   = cg_no_of_units,
   parameter int depth         = cg_depth
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [31:0]                          total,
   input  logic                                 read_req,
   output logic [element_width*no_of_units-1:0] read_data,
   output logic                                 read_valid,
   output logic                                 read_done,
   input  logic [31:0]                          rand_addr,
   output logic [element_width*no_of_units-1:0] rand_data,
   input  logic                                 wr_en,
   input  logic [31:0]                          wr_addr,
   input  logic [element_width*no_of_units-1:0] wr_data,
   input  logic                                 swap,
   output logic                                 err
);

   localparam int          row_width  = element_width * no_of_units;
   localparam int          addr_width = cg_addr_width(depth);
   localparam logic [31:0] depth_w    = 32'(depth);
   localparam logic [31:0] units_w    = 32'(no_of_units);

   logic                  bank_sel;
   logic                  loaded;
   logic [31:0]           rows_q;
   logic [31:0]           rd_ptr;
   logic                  read_sel_q;
   logic                  rand_sel_q;
   logic                  rand_oob_q;

   logic [31:0]           rows_quot;
   logic [31:0]           rows_new;
   logic [31:0]           rows_eff;
   logic                  rows_partial;
   logic                  rows_clamped;
   logic                  latch_rows;

   logic                  read_ok;
   logic                  read_bad;
   logic                  read_last;
   logic                  wr_ok;
   logic                  wr_bad;
   logic                  rand_oob;

   logic [addr_width-1:0] rd_idx;
   logic [addr_width-1:0] wr_idx;
   logic [addr_width-1:0] rand_idx;

   logic                  a_we;
   logic                  b_we;
   logic                  a_rd_en;
   logic                  b_rd_en;
   logic [row_width-1:0]  a_rd0;
   logic [row_width-1:0]  a_rd1;
   logic [row_width-1:0]  b_rd0;
   logic [row_width-1:0]  b_rd1;

   // Row count derived from total. A count larger than a bank can hold is
   // clamped to depth and flagged, so the stream never addresses past the
   // end of the bank. Until the first post-reset edge has latched rows_q,
   // the freshly computed value stands in for it, so a read_req on that
   // very first cycle sees the right row count.
   always_comb begin
      rows_quot    = total / units_w;
      rows_partial = (total % units_w) != 32'd0;
      rows_clamped = rows_quot > depth_w;
      rows_new     = rows_clamped ? depth_w : rows_quot;
      latch_rows   = !loaded || swap;
      rows_eff     = loaded ? rows_q : rows_new;
   end

   // Request qualification. Everything here looks at the pre-swap state, so
   // a read or write that coincides with swap lands on the old banks.
   always_comb begin
      read_ok   = read_req && (rd_ptr < rows_eff);
      read_bad  = read_req && !read_ok;
      read_last = (rd_ptr + 32'd1) == rows_eff;
      wr_ok     = wr_en && (wr_addr < depth_w);
      wr_bad    = wr_en && !wr_ok;
      rand_oob  = rand_addr >= depth_w;
   end

   // Bank steering: bank_sel==0 means A is read, B is written.
   // Out-of-range random addresses read row 0 and have their result zeroed.
   always_comb begin
      rd_idx   = rd_ptr[addr_width-1:0];
      wr_idx   = wr_addr[addr_width-1:0];
      rand_idx = rand_oob ? '0 : rand_addr[addr_width-1:0];
      a_rd_en  = read_ok && !bank_sel;
      b_rd_en  = read_ok && bank_sel;
      a_we     = wr_ok && bank_sel;
      b_we     = wr_ok && !bank_sel;
   end

   // Control state. rd_ptr stops at rows and only swap or reset restarts it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bank_sel   <= 1'b0;
         loaded     <= 1'b0;
         rows_q     <= '0;
         rd_ptr     <= '0;
         read_valid <= 1'b0;
         read_done  <= 1'b0;
         read_sel_q <= 1'b0;
         rand_sel_q <= 1'b0;
         rand_oob_q <= 1'b0;
         err        <= 1'b0;
      end else begin
         loaded     <= 1'b1;
         read_valid <= read_ok;
         read_done  <= read_ok && read_last;
         rand_sel_q <= bank_sel;
         rand_oob_q <= rand_oob;

         if (latch_rows) begin
            rows_q <= rows_new;
         end

         if (swap) begin
            bank_sel <= !bank_sel;
            rd_ptr   <= '0;
         end else if (read_ok) begin
            rd_ptr <= rd_ptr + 32'd1;
         end

         if (read_ok) begin
            read_sel_q <= bank_sel;
         end

         if (read_bad || wr_bad || (latch_rows && (rows_partial || rows_clamped))) begin
            err <= 1'b1;
         end
      end
   end

   cg_row_ram #(
      .width      (row_width),
      .depth      (depth),
      .addr_width (addr_width)
   ) u_bank_a (
      .clk      (clk),
      .reset    (reset),
      .we       (a_we),
      .wr_addr  (wr_idx),
      .wr_data  (wr_data),
      .rd0_en   (a_rd_en),
      .rd0_addr (rd_idx),
      .rd0_data (a_rd0),
      .rd1_addr (rand_idx),
      .rd1_data (a_rd1)
   );

   cg_row_ram #(
      .width      (row_width),
      .depth      (depth),
      .addr_width (addr_width)
   ) u_bank_b (
      .clk      (clk),
      .reset    (reset),
      .we       (b_we),
      .wr_addr  (wr_idx),
      .wr_data  (wr_data),
      .rd0_en   (b_rd_en),
      .rd0_addr (rd_idx),
      .rd0_data (b_rd0),
      .rd1_addr (rand_idx),
      .rd1_data (b_rd1)
   );

   // Only the serving bank's port 0 moves on a read, so following the bank
   // of the most recent read keeps read_data steady across later swaps.
   always_comb begin
      read_data = read_sel_q ? b_rd0 : a_rd0;
      rand_data = rand_oob_q ? '0 : (rand_sel_q ? b_rd1 : a_rd1);
   end

endmodule

// File: tb/tb_cg_vector_bank.sv
// ---------------------------------------------------------------------------
// tb_cg_vector_bank
// Directed bench for cg_vector_bank: sequential streaming, exhaustion,
// swap/write/read collisions, the random port, dropped writes, reset
// behaviour and partial row counts. Expected stream rows are queued when a
// read is requested and popped when read_valid is due.
// ---------------------------------------------------------------------------
module tb_cg_vector_bank;
   import cg_pkg::*;

   localparam int ew = 32;
   localparam int nu = 8;
   localparam int dp = 64;
   localparam int rw = ew * nu;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   total;
   logic          read_req;
   logic [rw-1:0] read_data;
   logic          read_valid;
   logic          read_done;
   logic [31:0]   rand_addr;
   logic [rw-1:0] rand_data;
   logic          wr_en;
   logic [31:0]   wr_addr;
   logic [rw-1:0] wr_data;
   logic          swap;
   logic          err;

   logic [rw-1:0] exp_q [$];
   logic [rw-1:0] last_data;
   int            vectors;
   int            miscompares;

   always #5 clk = ~clk;

   cg_vector_bank #(
      .element_width (ew),
      .no_of_units   (nu),
      .depth         (dp)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .total      (total),
      .read_req   (read_req),
      .read_data  (read_data),
      .read_valid (read_valid),
      .read_done  (read_done),
      .rand_addr  (rand_addr),
      .rand_data  (rand_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .swap       (swap),
      .err        (err)
   );

   // A row with every element set to the same value.
   function automatic logic [rw-1:0] fill(input logic [ew-1:0] v);
      return {nu{v}};
   endfunction

   task automatic expectRow(input logic [rw-1:0] row);
      exp_q.push_back(row);
   endtask

   // Drive one cycle of inputs, then step to just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic rq, input logic sw,
                                input logic we, input logic [31:0] wa,
                                input logic [rw-1:0] wd, input logic [31:0] ra);
      reset     = rst;
      read_req  = rq;
      swap      = sw;
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      rand_addr = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic exp_valid, input logic exp_done);
      vectors++;
      assert (read_valid === exp_valid) else begin
         miscompares++;
         $error("[TB] FAIL %s.valid observed=%b expected=%b", tag, read_valid, exp_valid);
      end
      vectors++;
      assert (read_done === exp_done) else begin
         miscompares++;
         $error("[TB] FAIL %s.done observed=%b expected=%b", tag, read_done, exp_done);
      end
      if (exp_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=row", tag);
         end else begin
            last_data = exp_q.pop_front();
         end
      end
      vectors++;
      assert (read_data === last_data) else begin
         miscompares++;
         $error("[TB] FAIL %s.data observed=%h expected=%h", tag, read_data, last_data);
      end
   endtask

   task automatic checkRand(input string tag, input logic [rw-1:0] expected);
      vectors++;
      assert (rand_data === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s.rand observed=%h expected=%h", tag, rand_data, expected);
      end
   endtask

   task automatic checkErr(input string tag, input logic expected);
      vectors++;
      assert (err === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s.err observed=%b expected=%b", tag, err, expected);
      end
   endtask

   initial begin
      reset       = 1'b0;
      read_req    = 1'b0;
      swap        = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      rand_addr   = '0;
      total       = 32'd32;
      last_data   = '0;
      vectors     = 0;
      miscompares = 0;

      $display("[TB] reset state");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd0);
      checkOutput("reset", 1'b0, 1'b0);
      checkRand("reset", '0);
      checkErr("reset", 1'b0);

      $display("[TB] fill bank B, swap, fill bank A");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'(i), fill(32'(i + 1)), 32'd0);
         checkOutput("fill_b", 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, '0, 32'd0);
      checkOutput("swap1", 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'(i), fill(32'(16 + i)), 32'd0);
         checkOutput("fill_a", 1'b0, 1'b0);
      end

      $display("[TB] sequential read of bank B with idle gaps");
      for (int i = 0; i < 4; i++) begin
         expectRow(fill(32'(i + 1)));
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd0);
         checkOutput("seq", 1'b1, i == 3);
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd0);
         checkOutput("seq_hold", 1'b0, 1'b0);
      end
      checkErr("seq", 1'b0);

      $display("[TB] exhaustion");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd0);
      checkOutput("exhaust", 1'b0, 1'b0);
      checkErr("exhaust", 1'b1);

      $display("[TB] reset with a pending read");
      last_data = '0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd1);
      checkOutput("reset2", 1'b0, 1'b0);
      checkRand("reset2", '0);
      checkErr("reset2", 1'b0);

      $display("[TB] bank A preserved across reset");
      expectRow(fill(32'd16));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd1);
      checkOutput("preserve", 1'b1, 1'b0);
      checkRand("preserve", fill(32'd17));

      $display("[TB] swap colliding with write and read");
      expectRow(fill(32'd17));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'd2, fill(32'hAAAA_AAAA), 32'd2);
      checkOutput("collide", 1'b1, 1'b0);
      checkRand("collide", fill(32'd18));
      for (int i = 0; i < 4; i++) begin
         expectRow((i == 2) ? fill(32'hAAAA_AAAA) : fill(32'(i + 1)));
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd2);
         checkOutput("post_swap", 1'b1, i == 3);
         checkRand("post_swap", fill(32'hAAAA_AAAA));
      end

      $display("[TB] random port alongside an 8-row stream");
      total = 32'd64;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, '0, 32'd3);
      checkOutput("swap3", 1'b0, 1'b0);
      checkRand("swap3", fill(32'd4));
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra;
         ra = (i < 4) ? 32'd3 : 32'd5;
         expectRow(fill(32'(16 + i)));
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, ra);
         checkOutput("stream", 1'b1, i == 7);
         checkRand("stream", fill(32'd16 + ra));
      end
      checkErr("stream", 1'b0);

      $display("[TB] out-of-range write, then reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd64, fill(32'hDEAD_BEEF), 32'd0);
      checkOutput("badwr", 1'b0, 1'b0);
      checkErr("badwr", 1'b1);
      last_data = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd7);
      checkOutput("reset3", 1'b0, 1'b0);
      checkRand("reset3", '0);
      checkErr("reset3", 1'b0);

      $display("[TB] partial row count");
      total = 32'd30;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd7);
      checkOutput("rows30", 1'b0, 1'b0);
      checkRand("rows30", fill(32'd23));
      checkErr("rows30", 1'b1);
      for (int i = 0; i < 3; i++) begin
         expectRow(fill(32'(16 + i)));
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd0);
         checkOutput("rows30_read", 1'b1, i == 2);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 32'd0);
      checkOutput("rows30_extra", 1'b0, 1'b0);

      $display("[TB] bank B row 0 untouched by the dropped write");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, '0, 32'd0);
      checkRand("swap4", fill(32'd16));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd0);
      checkRand("b_row0", fill(32'd1));
      checkOutput("final", 1'b0, 1'b0);

      vectors++;
      assert (exp_q.size() == 0) else begin
         miscompares++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
